// File: rtl/pipe_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard controller:
// timer states, stage indices and a highest-set-bit search.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mc_state_t;

    localparam int STG_PC  = 0;
    localparam int STG_IF  = 1;
    localparam int STG_ID  = 2;
    localparam int STG_EX  = 3;
    localparam int STG_MEM = 4;
    localparam int STG_WB  = 5;

    // Returns -1 when no bit is set.
    function automatic int hsb(input logic [31:0] v);
        int r;
        r = -1;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

endpackage

// File: rtl/pipe_ctrl_mc.sv
// Multi-cycle stall timer: IDLE -> BUSY for N cycles -> DONE for one cycle.
// An abort from an applied younger-killing flush drops BUSY straight to IDLE.
module pipe_ctrl_mc
    import pipe_ctrl_pkg::*;
#(
    parameter int STAGES = 6,
    parameter int CNT_W  = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mc_start,
    input  logic [$clog2(STAGES)-1:0] mc_stage,
    input  logic [CNT_W-1:0]          mc_cycles,
    input  logic                      abort,
    output logic                      busy,
    output logic                      done
);

    mc_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (mc_start && (mc_cycles != '0) && (int'(mc_stage) < STAGES)) begin
                    state_d = BUSY;
                    cnt_d   = mc_cycles;
                end
            end
            BUSY: begin
                if (abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy = (state_q == BUSY);
    assign done = (state_q == DONE);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: merges stall, flush and multi-cycle timer requests
// into per-stage stall/flush vectors. Define PIPE_CTRL_STATS_EN for stall/flush counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int STAGES = 6,
    parameter int CNT_W  = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [STAGES-1:0]         stall_req,
    input  logic [STAGES-1:0]         flush_req,
    input  logic                      mc_start,
    input  logic [$clog2(STAGES)-1:0] mc_stage,
    input  logic [CNT_W-1:0]          mc_cycles,
    output logic [STAGES-1:0]         stall,
    output logic [STAGES-1:0]         flush,
    output logic                      flush_ack,
    output logic                      mc_busy,
    output logic                      mc_done
`ifdef PIPE_CTRL_STATS_EN
    ,
    output logic [31:0]               stall_cnt,
    output logic [31:0]               flush_cnt
`endif
);

    localparam logic [STAGES-1:0] ONE = STAGES'(1);

    logic [STAGES-1:0] eff, eff_m, stall_c, flush_c;
    logic              ack_c, abort;
    int                f_idx, k_idx;

    // Stall requests from stages younger than the flushing stage are squashed,
    // so they are masked before picking the highest stalling stage.
    always_comb begin
        eff     = stall_req | (mc_busy ? (ONE << mc_stage) : '0);
        f_idx   = hsb(32'(flush_req) & ~32'd1);
        eff_m   = '0;
        stall_c = '0;
        flush_c = '0;
        for (int i = 0; i < STAGES; i++) begin
            if (i >= f_idx) eff_m[i] = eff[i];
        end
        k_idx = hsb(32'(eff_m));
        ack_c = (f_idx > 0) && (k_idx < 0);
        for (int i = STG_PC; i < STAGES; i++) begin
            if (i <= k_idx) stall_c[i] = 1'b1;
            if ((k_idx >= 0) && (i == k_idx + 1)) flush_c[i] = 1'b1;
            if (ack_c && (i >= STG_IF) && (i < f_idx)) flush_c[i] = 1'b1;
        end
        abort = ack_c && (f_idx > int'(mc_stage));
    end

    assign stall     = rst ? stall_c : '0;
    assign flush     = rst ? flush_c : '0;
    assign flush_ack = rst ? ack_c : 1'b0;

    pipe_ctrl_mc #(
        .STAGES (STAGES),
        .CNT_W  (CNT_W)
    ) u_mc (
        .clk       (clk),
        .rst       (rst),
        .mc_start  (mc_start),
        .mc_stage  (mc_stage),
        .mc_cycles (mc_cycles),
        .abort     (abort),
        .busy      (mc_busy),
        .done      (mc_done)
    );

`ifdef PIPE_CTRL_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall[STG_PC] && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
            if (flush_ack && (flush_cnt != '1)) flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule
